// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: reduces each window of POOL signed samples to its
// maximum and queues the results in a 2-entry output FIFO. Frames of LENY
// samples may end with a partial window, and a frame's last result carries
// a tag that raises frame_done for one cycle after it is popped.
module maxpool_stream #(
  parameter int WIDTH = 8,
  parameter int LENY  = 5,
  parameter int POOL  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    frame_done
);

  // Counter widths never collapse to zero bits, so POOL=1 or LENY=1 still
  // gives legal vectors.
  localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int EW = (LENY > 1) ? $clog2(LENY) : 1;
  localparam logic [WW-1:0] WIN_LAST  = WW'(POOL - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(LENY - 1);

  logic [WW-1:0]             win_cnt_q, win_cnt_d;
  logic [EW-1:0]             elem_cnt_q, elem_cnt_d;
  logic signed [WIDTH-1:0]   max_q, max_d;
  logic [1:0][WIDTH-1:0]     mem_q, mem_d;
  logic [1:0]                last_q, last_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [1:0]                count_q, count_d;
  logic                      frame_done_q, frame_done_d;

  logic                      accept_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      close_s;
  logic                      frame_end_s;
  logic signed [WIDTH-1:0]   cand_s;

  // Handshake outputs come straight from FIFO state. Ready is also held low
  // while reset is applied, but never looks at m_ready_z.
  assign s_ready_y  = (~reset) & (count_q < 2'd2);
  assign m_valid_z  = (count_q != 2'd0);
  assign m_data_z   = $signed(mem_q[rd_ptr_q]);
  assign frame_done = frame_done_q;

  // Window maximum including the current sample; a fresh window starts from
  // the sample itself, and ties keep the value already held.
  always_comb begin
    cand_s = max_q;
    if (win_cnt_q == {WW{1'b0}}) begin
      cand_s = s_data_y;
    end else if (s_data_y > max_q) begin
      cand_s = s_data_y;
    end else begin
      cand_s = max_q;
    end
  end

  // Next-state for window/frame counters, running max and the output FIFO.
  always_comb begin
    accept_s     = s_valid_y & s_ready_y;
    pop_s        = m_valid_z & m_ready_z;
    frame_end_s  = (elem_cnt_q == ELEM_LAST);
    close_s      = (win_cnt_q == WIN_LAST) | frame_end_s;
    push_s       = accept_s & close_s;

    win_cnt_d    = win_cnt_q;
    elem_cnt_d   = elem_cnt_q;
    max_d        = max_q;
    mem_d        = mem_q;
    last_d       = last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_done_d = 1'b0;

    if (accept_s) begin
      max_d = cand_s;
      if (frame_end_s) begin
        // A new frame always opens a fresh window.
        elem_cnt_d = {EW{1'b0}};
        win_cnt_d  = {WW{1'b0}};
      end else begin
        elem_cnt_d = elem_cnt_q + EW'(1'b1);
        if (win_cnt_q == WIN_LAST) begin
          win_cnt_d = {WW{1'b0}};
        end else begin
          win_cnt_d = win_cnt_q + WW'(1'b1);
        end
      end
    end else begin
      max_d = max_q;
    end

    if (push_s) begin
      mem_d[wr_ptr_q]  = cand_s;
      last_d[wr_ptr_q] = frame_end_s;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d     = ~rd_ptr_q;
      frame_done_d = last_q[rd_ptr_q];
    end else begin
      rd_ptr_d     = rd_ptr_q;
      frame_done_d = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset that drops any partial window and
  // any queued results.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q    <= {WW{1'b0}};
      elem_cnt_q   <= {EW{1'b0}};
      max_q        <= {WIDTH{1'b0}};
      mem_q        <= {(2*WIDTH){1'b0}};
      last_q       <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      elem_cnt_q   <= elem_cnt_d;
      max_q        <= max_d;
      mem_q        <= mem_d;
      last_q       <= last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
